idma_evt_collector: RTL and testbench
=====================================

Name: idma_evt_collector

Overview:
- Sits directly downstream of the iDMA memory-mapped controller and consumes its per-channel start/done/error pulses for AXI2OBI (a2o, L2→L1) and OBI2AXI (o2a, L1→L2).
- Tracks outstanding transfers and saturating error counts per channel.
- Latches maskable sticky pending events, drives one level IRQ to the core, and emits single-cycle "channel idle" events to the tile event unit.

Parameters:
- CNT_W, 4: width of each outstanding-transfer counter; saturates at 2^CNT_W-1.
- ERR_CNT_W, 8: width of each error counter; saturates at 2^ERR_CNT_W-1.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, asynchronous, active-high.
- clear_i, in, 1: synchronous clear of all state; same effect as reset.
- a2o_start_i, in, 1: a2o transfer start pulse.
- a2o_done_i, in, 1: a2o transfer done pulse.
- a2o_error_i, in, 1: a2o transfer error pulse.
- o2a_start_i, in, 1: o2a transfer start pulse.
- o2a_done_i, in, 1: o2a transfer done pulse.
- o2a_error_i, in, 1: o2a transfer error pulse.
- irq_mask_i, in, 6: per-bit enable of pending into irq_o.
- ack_i, in, 6: write-1-to-clear of pending bits; single-cycle strobe.
- pending_o, out, 6: sticky events {o2a_err, o2a_idle, o2a_done, a2o_err, a2o_idle, a2o_done}.
- irq_o, out, 1: |(pending_o & irq_mask_i).
- idle_evt_o, out, 2: [0] a2o, [1] o2a; one-cycle pulse when the channel's outstanding count returns to 0.
- a2o_outstanding_o, out, CNT_W: a2o outstanding transfer count.
- o2a_outstanding_o, out, CNT_W: o2a outstanding transfer count.
- a2o_err_cnt_o, out, ERR_CNT_W: a2o error count.
- o2a_err_cnt_o, out, ERR_CNT_W: o2a error count.
- fault_o, out, 4: sticky {o2a_underflow, o2a_overflow, a2o_underflow, a2o_overflow}.

Behaviour:
- Reset/clear:
  - All registers go to 0, so every output is 0 and irq_o is 0.
  - clear_i has priority over all events in the same cycle.
- Per-channel completion: comp = done_i | error_i. Done and error in the same cycle count as one completion.
- Outstanding counter next value:
  - start & !comp: +1. If already at max, hold and set the overflow fault.
  - comp & !start: -1. If already 0, hold at 0 and set the underflow fault.
  - start & comp: unchanged. Neither overflow nor underflow is flagged, even at the saturation bounds.
  - Otherwise: hold.
- Idle event:
  - idle_evt_o[ch] is registered. It pulses for exactly one cycle in the cycle after the counter transitions from 1 to 0.
  - No pulse on an underflow hold, or when the count stays 0.
- Error counter: increments on error_i and saturates at max. No wrap.
- Pending bits:
  - done bit is set by done_i; err bit is set by error_i; idle bit is set together with the idle event (same cycle as the idle_evt_o pulse).
  - Each bit clears only on ack_i[bit]. A set and an ack on the same bit in the same cycle leave it set (set wins).
  - Latency: input pulse in cycle N makes pending visible in cycle N+1. The idle bit is visible in N+1 relative to the completing pulse.
- irq_o is combinational from the pending register and irq_mask_i, with no extra cycle. Masking never clears pending.
- Fault bits are sticky until reset/clear. They do not drive irq_o.
- Inputs are treated as single-cycle pulses. A held level counts once per cycle.
- Reset mid-transfer: counters drop to 0. A later done then registers as underflow, which is intended.

Decomposition:
- Shared package (magia_tile_pkg) holds:
  - the pending bit-index localparams: A2O_DONE=0, A2O_IDLE=1, A2O_ERR=2, O2A_DONE=3, O2A_IDLE=4, O2A_ERR=5;
  - the fault bit indices;
  - a typedef for the 6-bit event vector.
- One sub-module, idma_ch_evt_tracker, instantiated twice (once per channel). It contains the outstanding counter, error counter, idle-event register, set strobes and fault bits.
- The top level holds the pending register, ack/mask logic and irq_o.

Test Plan:
- 3×a2o_start_i, then 3×a2o_done_i with irq_mask_i=6'h02 → a2o_outstanding_o goes 1,2,3,2,1,0. idle_evt_o[0] pulses once, the cycle after the 3rd done. irq_o=1 and stays high until ack_i=6'h02 → irq_o=0 next cycle.
- o2a_start_i and o2a_done_i in the same cycle with count=1 → count stays 1, no idle event, pending_o[O2A_DONE]=1.
- o2a_error_i with count 0 → fault_o[3]=1, count 0, o2a_err_cnt_o=1, pending_o[5]=1. An error_i on o2a for 300 pulses total (ERR_CNT_W=8) → o2a_err_cnt_o=255.
- With CNT_W=4, 16×a2o_start_i → count=15, fault_o[0]=1.
- a2o_done_i in the same cycle as ack_i[0] → pending_o[0] remains 1.
- Assert rst_i asynchronously mid-operation (count 2, pending 6'h3F) → all outputs 0 immediately. Repeat with clear_i → all outputs 0 next edge.

Source files
------------

// File: rtl/magia_tile_pkg.sv
// Shared definitions for the iDMA event collector: pending and fault bit positions
// and the 6-bit event vector type.
package magia_tile_pkg;

  localparam int A2O_DONE = 0;
  localparam int A2O_IDLE = 1;
  localparam int A2O_ERR  = 2;
  localparam int O2A_DONE = 3;
  localparam int O2A_IDLE = 4;
  localparam int O2A_ERR  = 5;

  localparam int FLT_A2O_OVF = 0;
  localparam int FLT_A2O_UNF = 1;
  localparam int FLT_O2A_OVF = 2;
  localparam int FLT_O2A_UNF = 3;

  typedef logic [5:0] evt_vec_t;

endpackage

// File: rtl/idma_ch_evt_tracker.sv
// Per-channel tracker: outstanding-transfer counter, saturating error counter,
// registered idle pulse, pending set strobes and sticky over/underflow faults.
module idma_ch_evt_tracker #(
  parameter int CNT_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic                 done_i,
  input  logic                 error_i,
  output logic [CNT_W-1:0]     outstanding_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 idle_evt_o,
  output logic                 set_done_o,
  output logic                 set_idle_o,
  output logic                 set_err_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam logic [CNT_W-1:0]     CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [ERR_CNT_W-1:0] err_d, err_q;
  logic                 idle_d, idle_q;
  logic                 ovf_d, ovf_q;
  logic                 unf_d, unf_q;
  logic                 comp;
  logic                 to_idle;

  // Done and error together are a single completion.
  assign comp = done_i | error_i;

  always_comb begin
    cnt_d   = cnt_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    to_idle = 1'b0;
    if (start_i && !comp) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (comp && !start_i) begin
      if (cnt_q == '0) begin
        unf_d = 1'b1;
      end else begin
        cnt_d   = cnt_q - 1'b1;
        to_idle = (cnt_q == CNT_ONE);
      end
    end
    if (error_i && err_q != ERR_MAX) err_d = err_q + 1'b1;
    idle_d = to_idle;
    if (clear_i) begin
      cnt_d  = '0;
      err_d  = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      idle_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      err_q  <= '0;
      idle_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      idle_q <= idle_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_cnt_o     = err_q;
  assign idle_evt_o    = idle_q;
  assign overflow_o    = ovf_q;
  assign underflow_o   = unf_q;
  // Strobes land in the pending register on the same edge as the idle pulse.
  assign set_done_o    = done_i;
  assign set_err_o     = error_i;
  assign set_idle_o    = to_idle;

endmodule

// File: rtl/idma_evt_collector.sv
// Collects iDMA a2o/o2a start/done/error pulses into sticky pending events,
// a maskable level IRQ, per-channel idle pulses, counters and fault flags.
module idma_evt_collector
  import magia_tile_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 a2o_start_i,
  input  logic                 a2o_done_i,
  input  logic                 a2o_error_i,
  input  logic                 o2a_start_i,
  input  logic                 o2a_done_i,
  input  logic                 o2a_error_i,
  input  logic [5:0]           irq_mask_i,
  input  logic [5:0]           ack_i,
  output logic [5:0]           pending_o,
  output logic                 irq_o,
  output logic [1:0]           idle_evt_o,
  output logic [CNT_W-1:0]     a2o_outstanding_o,
  output logic [CNT_W-1:0]     o2a_outstanding_o,
  output logic [ERR_CNT_W-1:0] a2o_err_cnt_o,
  output logic [ERR_CNT_W-1:0] o2a_err_cnt_o,
  output logic [3:0]           fault_o
);

  evt_vec_t pending_d, pending_q;
  evt_vec_t set_vec;
  logic     a2o_set_done, a2o_set_idle, a2o_set_err;
  logic     o2a_set_done, o2a_set_idle, o2a_set_err;
  logic     a2o_ovf, a2o_unf, o2a_ovf, o2a_unf;

  idma_ch_evt_tracker #(.CNT_W(CNT_W), .ERR_CNT_W(ERR_CNT_W)) u_a2o (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .start_i       (a2o_start_i),
    .done_i        (a2o_done_i),
    .error_i       (a2o_error_i),
    .outstanding_o (a2o_outstanding_o),
    .err_cnt_o     (a2o_err_cnt_o),
    .idle_evt_o    (idle_evt_o[0]),
    .set_done_o    (a2o_set_done),
    .set_idle_o    (a2o_set_idle),
    .set_err_o     (a2o_set_err),
    .overflow_o    (a2o_ovf),
    .underflow_o   (a2o_unf)
  );

  idma_ch_evt_tracker #(.CNT_W(CNT_W), .ERR_CNT_W(ERR_CNT_W)) u_o2a (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .start_i       (o2a_start_i),
    .done_i        (o2a_done_i),
    .error_i       (o2a_error_i),
    .outstanding_o (o2a_outstanding_o),
    .err_cnt_o     (o2a_err_cnt_o),
    .idle_evt_o    (idle_evt_o[1]),
    .set_done_o    (o2a_set_done),
    .set_idle_o    (o2a_set_idle),
    .set_err_o     (o2a_set_err),
    .overflow_o    (o2a_ovf),
    .underflow_o   (o2a_unf)
  );

  always_comb begin
    set_vec           = '0;
    set_vec[A2O_DONE] = a2o_set_done;
    set_vec[A2O_IDLE] = a2o_set_idle;
    set_vec[A2O_ERR]  = a2o_set_err;
    set_vec[O2A_DONE] = o2a_set_done;
    set_vec[O2A_IDLE] = o2a_set_idle;
    set_vec[O2A_ERR]  = o2a_set_err;
  end

  // A set and an ack on the same bit in one cycle leave the bit set.
  always_comb begin
    pending_d = (pending_q & ~ack_i) | set_vec;
    if (clear_i) pending_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  always_comb begin
    fault_o              = '0;
    fault_o[FLT_A2O_OVF] = a2o_ovf;
    fault_o[FLT_A2O_UNF] = a2o_unf;
    fault_o[FLT_O2A_OVF] = o2a_ovf;
    fault_o[FLT_O2A_UNF] = o2a_unf;
  end

  assign pending_o = pending_q;
  assign irq_o     = |(pending_q & irq_mask_i);

endmodule

// File: tb/tb_idma_evt_collector.sv
// Directed bench for idma_evt_collector: a vector table for the basic flows plus
// hand-written sequences for saturation, set-vs-ack, async reset and clear.
module tb_idma_evt_collector;

  logic       clk = 1'b0;
  logic       rst_i, clear_i;
  logic       a2o_start_i, a2o_done_i, a2o_error_i;
  logic       o2a_start_i, o2a_done_i, o2a_error_i;
  logic [5:0] irq_mask_i, ack_i;
  logic [5:0] pending_o;
  logic       irq_o;
  logic [1:0] idle_evt_o;
  logic [3:0] a2o_outstanding_o, o2a_outstanding_o;
  logic [7:0] a2o_err_cnt_o, o2a_err_cnt_o;
  logic [3:0] fault_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  idma_evt_collector #(.CNT_W(4), .ERR_CNT_W(8)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .clear_i           (clear_i),
    .a2o_start_i       (a2o_start_i),
    .a2o_done_i        (a2o_done_i),
    .a2o_error_i       (a2o_error_i),
    .o2a_start_i       (o2a_start_i),
    .o2a_done_i        (o2a_done_i),
    .o2a_error_i       (o2a_error_i),
    .irq_mask_i        (irq_mask_i),
    .ack_i             (ack_i),
    .pending_o         (pending_o),
    .irq_o             (irq_o),
    .idle_evt_o        (idle_evt_o),
    .a2o_outstanding_o (a2o_outstanding_o),
    .o2a_outstanding_o (o2a_outstanding_o),
    .a2o_err_cnt_o     (a2o_err_cnt_o),
    .o2a_err_cnt_o     (o2a_err_cnt_o),
    .fault_o           (fault_o)
  );

  // ev bit order: [0]a2o_start [1]a2o_done [2]a2o_error [3]o2a_start [4]o2a_done [5]o2a_error
  typedef struct {
    logic [5:0] ev;
    logic [5:0] mask;
    logic [5:0] ack;
    logic [3:0] ao;
    logic [3:0] oo;
    logic [1:0] idle;
    logic [5:0] pend;
    logic       irq;
    logic [3:0] flt;
    logic [7:0] aec;
    logic [7:0] oec;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle of pulses from a negedge; return at the following negedge.
  task automatic pulse(input logic [5:0] ev, input logic [5:0] ack, input logic clr);
    {o2a_error_i, o2a_done_i, o2a_start_i, a2o_error_i, a2o_done_i, a2o_start_i} = ev;
    ack_i   = ack;
    clear_i = clr;
    @(posedge clk);
    @(negedge clk);
    {o2a_error_i, o2a_done_i, o2a_start_i, a2o_error_i, a2o_done_i, a2o_start_i} = '0;
    ack_i   = '0;
    clear_i = 1'b0;
  endtask

  function automatic logic [53:0] all_outs();
    return {pending_o, irq_o, idle_evt_o, a2o_outstanding_o, o2a_outstanding_o,
            a2o_err_cnt_o, o2a_err_cnt_o, fault_o, 16'h0};
  endfunction

  // Leaves a2o count 2 and all six pending bits set.
  task automatic build_busy_state();
    pulse(6'h01, 6'h00, 1'b0);  // a2o start
    pulse(6'h04, 6'h00, 1'b0);  // a2o error completes -> idle + err
    pulse(6'h02, 6'h00, 1'b0);  // a2o done at 0 -> done, underflow
    pulse(6'h08, 6'h00, 1'b0);  // o2a start
    pulse(6'h10, 6'h00, 1'b0);  // o2a done -> done + idle
    pulse(6'h20, 6'h00, 1'b0);  // o2a error at 0 -> err, underflow
    pulse(6'h01, 6'h00, 1'b0);
    pulse(6'h01, 6'h00, 1'b0);
  endtask

  initial begin
    //          ev     mask   ack    ao oo idle pend  irq flt aec oec
    vecs[0]  = '{6'h01, 6'h02, 6'h00, 1, 0, 0, 6'h00, 0, 0, 0, 0};
    vecs[1]  = '{6'h01, 6'h02, 6'h00, 2, 0, 0, 6'h00, 0, 0, 0, 0};
    vecs[2]  = '{6'h01, 6'h02, 6'h00, 3, 0, 0, 6'h00, 0, 0, 0, 0};
    vecs[3]  = '{6'h02, 6'h02, 6'h00, 2, 0, 0, 6'h01, 0, 0, 0, 0};
    vecs[4]  = '{6'h02, 6'h02, 6'h00, 1, 0, 0, 6'h01, 0, 0, 0, 0};
    vecs[5]  = '{6'h02, 6'h02, 6'h00, 0, 0, 1, 6'h03, 1, 0, 0, 0};
    vecs[6]  = '{6'h00, 6'h02, 6'h00, 0, 0, 0, 6'h03, 1, 0, 0, 0};
    vecs[7]  = '{6'h00, 6'h02, 6'h02, 0, 0, 0, 6'h01, 0, 0, 0, 0};
    vecs[8]  = '{6'h00, 6'h00, 6'h01, 0, 0, 0, 6'h00, 0, 0, 0, 0};
    vecs[9]  = '{6'h08, 6'h00, 6'h00, 0, 1, 0, 6'h00, 0, 0, 0, 0};
    vecs[10] = '{6'h18, 6'h00, 6'h00, 0, 1, 0, 6'h08, 0, 0, 0, 0};
    vecs[11] = '{6'h10, 6'h00, 6'h00, 0, 0, 2, 6'h18, 0, 0, 0, 0};
    vecs[12] = '{6'h00, 6'h00, 6'h18, 0, 0, 0, 6'h00, 0, 0, 0, 0};
    vecs[13] = '{6'h20, 6'h00, 6'h00, 0, 0, 0, 6'h20, 0, 8, 0, 1};
    vecs[14] = '{6'h20, 6'h00, 6'h20, 0, 0, 0, 6'h20, 0, 8, 0, 2};
    vecs[15] = '{6'h00, 6'h20, 6'h00, 0, 0, 0, 6'h20, 1, 8, 0, 2};
    vecs[16] = '{6'h00, 6'h00, 6'h00, 0, 0, 0, 6'h20, 0, 8, 0, 2};

    rst_i = 1'b1;
    clear_i = 1'b0;
    {o2a_error_i, o2a_done_i, o2a_start_i, a2o_error_i, a2o_done_i, a2o_start_i} = '0;
    irq_mask_i = 6'h3F;
    ack_i = '0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'(all_outs() >> 16), 32'h0);
    rst_i = 1'b0;

    for (int i = 0; i < 17; i++) begin
      irq_mask_i = vecs[i].mask;
      pulse(vecs[i].ev, vecs[i].ack, 1'b0);
      check($sformatf("v%0d_a2o_cnt", i),  32'(a2o_outstanding_o), 32'(vecs[i].ao));
      check($sformatf("v%0d_o2a_cnt", i),  32'(o2a_outstanding_o), 32'(vecs[i].oo));
      check($sformatf("v%0d_idle", i),     32'(idle_evt_o),        32'(vecs[i].idle));
      check($sformatf("v%0d_pending", i),  32'(pending_o),         32'(vecs[i].pend));
      check($sformatf("v%0d_irq", i),      32'(irq_o),             32'(vecs[i].irq));
      check($sformatf("v%0d_fault", i),    32'(fault_o),           32'(vecs[i].flt));
      check($sformatf("v%0d_a2o_err", i),  32'(a2o_err_cnt_o),     32'(vecs[i].aec));
      check($sformatf("v%0d_o2a_err", i),  32'(o2a_err_cnt_o),     32'(vecs[i].oec));
    end

    // o2a error counter saturation: 2 so far, 253 more reach 255, 45 more hold it.
    for (int i = 0; i < 253; i++) pulse(6'h20, 6'h00, 1'b0);
    check("o2a_err_255", 32'(o2a_err_cnt_o), 32'd255);
    for (int i = 0; i < 45; i++) pulse(6'h20, 6'h00, 1'b0);
    check("o2a_err_sat", 32'(o2a_err_cnt_o), 32'd255);
    check("o2a_cnt_after_errs", 32'(o2a_outstanding_o), 32'd0);

    // a2o overflow: 15 starts fill the counter, the 16th flags overflow.
    for (int i = 0; i < 15; i++) pulse(6'h01, 6'h00, 1'b0);
    check("a2o_cnt_15", 32'(a2o_outstanding_o), 32'd15);
    check("no_ovf_yet", 32'(fault_o), 32'h8);
    pulse(6'h01, 6'h00, 1'b0);
    check("a2o_cnt_hold", 32'(a2o_outstanding_o), 32'd15);
    check("a2o_ovf", 32'(fault_o), 32'h9);

    // start+done at max: unchanged, no new fault, done becomes pending.
    pulse(6'h03, 6'h00, 1'b0);
    check("sd_at_max_cnt", 32'(a2o_outstanding_o), 32'd15);
    check("sd_at_max_flt", 32'(fault_o), 32'h9);
    check("sd_at_max_pend", 32'(pending_o), 32'h21);

    // done with ack on the same bit: set wins.
    pulse(6'h02, 6'h01, 1'b0);
    check("set_wins_pend", 32'(pending_o), 32'h21);
    check("set_wins_cnt", 32'(a2o_outstanding_o), 32'd14);
    pulse(6'h00, 6'h01, 1'b0);
    check("ack_clears", 32'(pending_o), 32'h20);

    // Asynchronous reset mid-operation.
    pulse(6'h00, 6'h00, 1'b1);
    check("clear_before_build", 32'(all_outs() >> 16), 32'h0);
    irq_mask_i = 6'h3F;
    build_busy_state();
    check("busy_pend", 32'(pending_o), 32'h3F);
    check("busy_cnt", 32'(a2o_outstanding_o), 32'd2);
    check("busy_irq", 32'(irq_o), 32'd1);
    #2 rst_i = 1'b1;
    #1 check("async_rst_pend", 32'(pending_o), 32'h0);
    check("async_rst_all", 32'(all_outs() >> 16), 32'h0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    // Synchronous clear wins over events arriving in the same cycle.
    build_busy_state();
    check("busy2_pend", 32'(pending_o), 32'h3F);
    pulse(6'h3F, 6'h00, 1'b1);
    check("clear_all", 32'(all_outs() >> 16), 32'h0);
    check("clear_irq", 32'(irq_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
